// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable response latency
//
// Purpose: answers load/store requests from the pipeline's data-memory port after
// WAIT_CYCLES extra cycles, so stall logic sees realistic memory latency.
// Storage is a word array that reset does not clear. The access (read and
// byte-masked write) happens on the edge that enters RESP. The response
// registers load on that same edge.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready      request handshake; ready only in IDLE
//   req_we, req_op             1=store / 0=load, RV funct3 width code
//   req_addr, req_wdata        byte address, store data (low bytes for B/H)
//   rsp_valid / rsp_ready      response handshake; outputs frozen until consumed
//   rsp_rdata, rsp_err         extended load data (0 for stores/errors), error flag
module dmem_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [7:0] CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [2:0]            op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Request being committed: with WAIT_CYCLES=0 RESP is entered straight from
   // IDLE, before the latch holds anything, so the live request is used there.
   logic                  c_we;
   logic [2:0]            c_op;
   logic [ADDR_WIDTH-1:0] c_addr;
   logic [DATA_WIDTH-1:0] c_wdata;
   logic [IDX_W-1:0]      idx;
   logic [1:0]            lane;
   logic [DATA_WIDTH-1:0] mem_word;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_data;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] wr_shift;
   logic [DATA_WIDTH-1:0] wr_word;
   logic                  misaligned, out_of_range, illegal_op, c_err;
   logic                  commit, mem_we;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         we_q    <= 1'b0;
         op_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               op_d    = req_op;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready = (state_q == S_IDLE);
      rsp_valid = (state_q == S_RESP);
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
   end

   // ---------------- access datapath ----------------
   always_comb begin
      c_we    = (state_q == S_IDLE) ? req_we    : we_q;
      c_op    = (state_q == S_IDLE) ? req_op    : op_q;
      c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
      c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

      idx      = c_addr[IDX_W+1:2];
      lane     = c_addr[1:0];
      mem_word = mem[idx];

      // op[1:0]: 00 byte, 01 half, 10 word; op[2] selects the unsigned variants
      misaligned   = ((c_op[1:0] == 2'b01) && c_addr[0]) ||
                     ((c_op[1:0] == 2'b10) && (c_addr[1:0] != 2'b00));
      out_of_range = (c_addr >> (IDX_W + 2)) != '0;
      illegal_op   = (c_op == 3'b011) || (c_op == 3'b110) || (c_op == 3'b111) ||
                     (c_we && c_op[2]);
      c_err        = misaligned || out_of_range || illegal_op;

      ld_byte = mem_word[{lane, 3'b000} +: 8];
      ld_half = lane[1] ? mem_word[31:16] : mem_word[15:0];
      case (c_op[1:0])
         2'b00:   ld_data = {{(DATA_WIDTH-8){ld_byte[7] & ~c_op[2]}}, ld_byte};
         2'b01:   ld_data = {{(DATA_WIDTH-16){ld_half[15] & ~c_op[2]}}, ld_half};
         default: ld_data = mem_word;
      endcase

      case (c_op[1:0])
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = 4'b0011 << lane;
         default: be = 4'b1111;
      endcase
      wr_shift = c_wdata << {lane, 3'b000};
      for (int i = 0; i < 4; i++) begin
         wr_word[i*8 +: 8] = be[i] ? wr_shift[i*8 +: 8] : mem_word[i*8 +: 8];
      end

      commit = (state_q != S_RESP) && (state_d == S_RESP);
      mem_we = commit && c_we && !c_err;

      rdata_d = rdata_q;
      err_d   = err_q;
      if (commit) begin
         rdata_d = (c_err || c_we) ? '0 : ld_data;
         err_d   = c_err;
      end else if ((state_q == S_RESP) && rsp_ready) begin
         rdata_d = '0;
         err_d   = 1'b0;
      end
   end

   // Storage deliberately has no reset: contents survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx] <= wr_word;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;

   typedef struct {
      string       name;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel;
   logic        req_valid, req_we, rsp_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;

   logic        req_ready_2, rsp_valid_2, rsp_err_2;
   logic [31:0] rsp_rdata_2;
   logic        req_ready_0, rsp_valid_0, rsp_err_0;
   logic [31:0] rsp_rdata_0;

   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   // sel=1 drives the WAIT_CYCLES=2 instance, sel=0 the WAIT_CYCLES=0 one
   assign req_ready = sel ? req_ready_2 : req_ready_0;
   assign rsp_valid = sel ? rsp_valid_2 : rsp_valid_0;
   assign rsp_err   = sel ? rsp_err_2   : rsp_err_0;
   assign rsp_rdata = sel ? rsp_rdata_2 : rsp_rdata_0;

   dmem_responder #(.WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid & sel), .req_ready(req_ready_2),
      .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready | ~sel),
      .rsp_rdata(rsp_rdata_2), .rsp_err(rsp_err_2)
   );

   dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid & ~sel), .req_ready(req_ready_0),
      .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready | sel),
      .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge. Returns at the negedge where rsp_valid is first seen.
   task automatic issue(input string name, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] erd, input logic eerr);
      int n;
      int lat;
      exp_t e;
      e.name = name;
      e.err = eerr;
      e.rdata = erd;
      exp_q.push_back(e);
      req_we = we;
      req_op = op;
      req_addr = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_accept"}, 64'(req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, 64'(lat), sel ? 64'd3 : 64'd1);
   endtask

   task automatic txn(input string name, input logic we, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] erd, input logic eerr);
      issue(name, we, op, addr, wdata, erd, eerr);
      @(negedge clk);
   endtask

   initial begin
      int acc;
      exp_t e;
      sel = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_op = 3'd0;
      req_addr = '0;
      req_wdata = '0;

      fork
         forever begin
            @(negedge clk);
            #1;
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_rsp: got err=%0b rdata=0x%0h, expected no response",
                           rsp_err, rsp_rdata);
               end else begin
                  e = exp_q.pop_front();
                  check({e.name, "_rsp"}, {31'd0, rsp_err, rsp_rdata}, {31'd0, e.err, e.rdata});
               end
            end
         end
         begin
            #200000;
            $display("FAIL watchdog: got timeout, expected completion");
            $fatal(1);
         end
      join_none

      // reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_dut2", {29'd0, req_ready, rsp_valid, rsp_err, rsp_rdata},
            {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
      check("reset_dut0", {29'd0, req_ready_0, rsp_valid_0, rsp_err_0, rsp_rdata_0},
            {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});

      // reset during WAIT abandons an uncommitted store
      txn("sw_10_old", 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0);
      req_we = 1'b1;
      req_op = 3'b010;
      req_addr = 32'h10;
      req_wdata = 32'hDEADBEEF;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("in_wait_ready", 64'(req_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check("async_reset", {30'd0, req_ready, rsp_valid, rsp_err, rsp_rdata},
            {30'd0, 1'b1, 1'b0, 1'b0, 32'h0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn("lw_10_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h11223344, 1'b0);

      // word, byte and half accesses
      txn("sw_20", 1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 1'b0);
      txn("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0);
      txn("sb_21", 1'b1, 3'b000, 32'h21, 32'hFFFFFF80, 32'h0, 1'b0);
      txn("lb_21", 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
      txn("lbu_21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h00000080, 1'b0);
      txn("lw_20_b", 1'b0, 3'b010, 32'h20, 32'h0, 32'h12348078, 1'b0);
      txn("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 32'h00001234, 1'b0);

      // errors: no write, rdata 0
      txn("lw_mis", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
      txn("sh_mis", 1'b1, 3'b001, 32'h23, 32'hFFFFFFFF, 32'h0, 1'b1);
      txn("lh_mis", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1);
      txn("lw_oor", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
      txn("sw_oor_hi", 1'b1, 3'b010, 32'h80000020, 32'hFFFFFFFF, 32'h0, 1'b1);
      txn("sw_op_bu", 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
      txn("ld_op_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
      txn("lw_20_unch", 1'b0, 3'b010, 32'h20, 32'h0, 32'h12348078, 1'b0);

      // backpressure: outputs frozen, extra request ignored
      rsp_ready = 1'b0;
      issue("lw_bp", 1'b0, 3'b010, 32'h20, 32'h0, 32'h12348078, 1'b0);
      req_we = 1'b1;
      req_op = 3'b010;
      req_addr = 32'h20;
      req_wdata = 32'h0;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold", {30'd0, rsp_valid, req_ready, rsp_err, rsp_rdata},
               {30'd0, 1'b1, 1'b0, 1'b0, 32'h12348078});
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_done", {62'd0, rsp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
      txn("lw_20_after_bp", 1'b0, 3'b010, 32'h20, 32'h0, 32'h12348078, 1'b0);

      // upper half store, signed/unsigned loads, last word in range
      txn("sh_22", 1'b1, 3'b001, 32'h22, 32'h5555ABCD, 32'h0, 1'b0);
      txn("lh_22_neg", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFABCD, 1'b0);
      txn("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000ABCD, 1'b0);
      txn("lb_23", 1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFFAB, 1'b0);
      txn("lw_20_c", 1'b0, 3'b010, 32'h20, 32'h0, 32'hABCD8078, 1'b0);
      txn("sw_ffc", 1'b1, 3'b010, 32'hFFC, 32'h0BADF00D, 32'h0, 1'b0);
      txn("lw_ffc", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0BADF00D, 1'b0);

      // zero-wait instance: latency and throughput
      sel = 1'b0;
      @(negedge clk);
      txn("w0_sw_40", 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
      txn("w0_lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
      for (int i = 0; i < 4; i++) begin
         e.name = "w0_stream";
         e.err = 1'b0;
         e.rdata = 32'hCAFEF00D;
         exp_q.push_back(e);
      end
      req_we = 1'b0;
      req_op = 3'b010;
      req_addr = 32'h40;
      req_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         check("w0_ready_pattern", 64'(req_ready), 64'((i % 2) == 0));
         if (req_ready) acc++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("w0_throughput", 64'(acc), 64'd4);

      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
